// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and combinational helpers for the PWM output stage.
package pwm_peripheral_pkg;

  localparam int PWM_BITS        = 8;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int NUM_OUT         = 16;

  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_BITS-1:0] COUNT_MAX = 8'hFF;

  // Full-scale duty must mean 100% high, not 255/256, so it bypasses the compare.
  function automatic logic pwm_level(input logic [PWM_BITS-1:0] count,
                                     input logic [PWM_BITS-1:0] duty);
    return (count < duty) || (duty == DUTY_FULL);
  endfunction

  function automatic logic [NUM_OUT-1:0] out_mux(input logic [NUM_OUT-1:0] en_out,
                                                 input logic [NUM_OUT-1:0] en_pwm,
                                                 input logic               level);
    return en_out & (~en_pwm | {NUM_OUT{level}});
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and PWM period counter; flags the period boundary and period start.
module pwm_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [PWM_BITS-1:0] count_o,
  output logic                boundary_o,
  output logic                start_o
);

  localparam logic [7:0] PRESC_LAST = 8'(CLK_DIV - 1);

  logic [7:0]          presc_q, presc_d;
  logic [PWM_BITS-1:0] count_q, count_d;
  logic                tick_s;

  // Next-state for prescaler and counter; the counter wraps 255 -> 0 naturally.
  always_comb begin
    tick_s  = (presc_q == PRESC_LAST);
    presc_d = presc_q + 8'd1;
    count_d = count_q;
    if (tick_s) begin
      presc_d = 8'd0;
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 8'd0;
      count_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign boundary_o = tick_s && (count_q == COUNT_MAX);
  assign start_o    = (presc_q == 8'd0) && (count_q == 8'd0);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins static low, static high or PWM from the SPI control registers.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               pwm_period_start
);

  logic [PWM_BITS-1:0] count_s;
  logic                boundary_s;
  logic                start_s;
  logic                level_s;
  logic [NUM_OUT-1:0]  en_out_s;
  logic [NUM_OUT-1:0]  en_pwm_s;

  logic [PWM_BITS-1:0] duty_shadow_q, duty_shadow_d;
  logic [NUM_OUT-1:0]  out_q, out_d;
  logic                period_start_q, period_start_d;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .count_o    (count_s),
    .boundary_o (boundary_s),
    .start_o    (start_s)
  );

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Duty is only sampled at the period boundary so a period never sees a mid-cycle change.
  always_comb begin
    duty_shadow_d = duty_shadow_q;
    if (boundary_s) begin
      duty_shadow_d = pwm_duty_cycle;
    end else begin
      duty_shadow_d = duty_shadow_q;
    end
    level_s        = pwm_level(count_s, duty_shadow_q);
    out_d          = out_mux(en_out_s, en_pwm_s, level_s);
    period_start_d = start_s;
  end

  // Output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q  <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out              = out_q;
  assign pwm_period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench: stimulus queues expected pin values and period measurements, a monitor checks them.
`timescale 1ns/1ps
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        ps;

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_reg_out_7_0   (eo_lo),
    .en_reg_out_15_8  (eo_hi),
    .en_reg_pwm_7_0   (ep_lo),
    .en_reg_pwm_15_8  (ep_hi),
    .pwm_duty_cycle   (duty),
    .out              (out),
    .pwm_period_start (ps)
  );

  typedef struct {
    int          cyc;
    logic [15:0] out;
    logic        ps;
    string       name;
  } cyc_exp_t;

  typedef struct {
    int start;
    int high;
    int edges;
  } per_exp_t;

  cyc_exp_t cq[$];
  per_exp_t pq[$];
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Per measured period: cycles all-high, out[0] edges after the start cycle, next duty, delay before setting it.
  int         hi_t [8] = '{1664, 0, 0, 0, 3328, 13, 832, 2496};
  int         ed_t [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
  logic [7:0] nd_t [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h40, 8'hC0, 8'hC0};
  int         dl_t [8] = '{0, 0, 0, 0, 0, 0, 208, 0};

  initial forever #50 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_next(input string name, input logic [15:0] o, input logic p);
    cq.push_back('{cyc + 1, o, p, name});
  endtask

  task automatic wait_start(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (ps !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (ps !== 1'b1) chk("start_timeout", {31'd0, ps}, 32'd1);
    c = cyc;
  endtask

  // Monitor: measures each PWM period between start pulses and checks cycle-tagged expectations.
  initial begin
    int   last_start;
    int   hi;
    int   ed;
    int   sp;
    logic prev0;
    per_exp_t e;
    last_start = -1;
    hi = 0; ed = 0; sp = 0; prev0 = 1'b0;
    forever begin
      @(negedge clk);
      if (ps === 1'b1) begin
        while (pq.size() > 0 && pq[0].start < last_start) begin
          chk("period_missed", pq[0].start, last_start);
          void'(pq.pop_front());
        end
        if (pq.size() > 0 && pq[0].start == last_start) begin
          e = pq.pop_front();
          chk("period_len", cyc - last_start, 3328);
          chk("high_cycles", hi, e.high);
          chk("out0_edges", ed, e.edges);
          chk("split_cycles", sp, 0);
        end
        last_start = cyc;
        hi = 0; ed = 0; sp = 0;
      end
      if (out === 16'hFFFF) hi++;
      if (out !== 16'h0000 && out !== 16'hFFFF) sp++;
      if (ps !== 1'b1 && out[0] !== prev0) ed++;
      prev0 = out[0];
      while (cq.size() > 0 && cq[0].cyc <= cyc) begin
        if (cq[0].cyc < cyc) begin
          chk({cq[0].name, "_missed"}, cyc, cq[0].cyc);
        end else begin
          chk({cq[0].name, "_out"}, out, cq[0].out);
          chk({cq[0].name, "_start"}, {31'd0, ps}, {31'd0, cq[0].ps});
        end
        void'(cq.pop_front());
      end
    end
  end

  // Directed stimulus.
  initial begin
    int c;
    rst_n = 1'b0;
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'hFF;
    repeat (3) step();
    exp_next("rst_hold", 16'h0000, 1'b0);
    step();
    rst_n = 1'b1;
    exp_next("first_start", 16'h0000, 1'b1);
    step();
    ep_lo = 8'h00; ep_hi = 8'h00;
    exp_next("static_all_on", 16'hFFFF, 1'b0);
    step();
    eo_lo = 8'hFF; eo_hi = 8'h00;
    exp_next("static_low_byte", 16'h00FF, 1'b0);
    step();
    eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'hFF; ep_hi = 8'hFF;
    exp_next("disabled_pwm", 16'h0000, 1'b0);
    step();
    eo_lo = 8'hFF; eo_hi = 8'hFF;
    exp_next("pwm_duty0", 16'h0000, 1'b0);
    step();
    ep_lo = 8'hFF; ep_hi = 8'h00;
    exp_next("mixed_mode", 16'hFF00, 1'b0);
    step();
    eo_lo = 8'hA5; eo_hi = 8'hA5; ep_lo = 8'h0F; ep_hi = 8'h0F;
    exp_next("pattern_mix", 16'hA0A0, 1'b0);
    step();
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
    exp_next("all_pwm_duty0", 16'h0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wait_start(c);
      pq.push_back('{c, hi_t[i], ed_t[i]});
      repeat (dl_t[i]) @(posedge clk);
      #1;
      duty = nd_t[i];
    end

    wait_start(c);
    repeat (1655) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_high", out, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_out", out, 16'h0000);
    chk("async_clear_start", {31'd0, ps}, 32'd0);
    duty = 8'h80;
    step();
    exp_next("reset_hold", 16'h0000, 1'b0);
    step();
    rst_n = 1'b1;
    exp_next("restart_start", 16'h0000, 1'b1);
    pq.push_back('{cyc + 1, 0, 0});
    wait_start(c);
    wait_start(c);
    step();
    step();
    chk("pending_cycle_exp", cq.size(), 0);
    chk("pending_period_exp", pq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
